// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix pins plus the decoded-key outputs of keypad_scan
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic key_strobe;
  logic key_held;
  logic add;
  modport master(input row_n, output col_n, key_code, key_strobe, key_held, add);
  modport slave(output row_n, input col_n, key_code, key_strobe, key_held, add);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner/debouncer with add operand select; KEYPAD_AUTOREPEAT_EN enables auto-repeat
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_DLY = 5000000
) (
  input logic clk,
  input logic rst_n,
  keypad_scan_if.master kp
);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  logic [3:0] s1, rows, pat, code, acode;
  logic [1:0] st, ci, row_idx;
  logic [SW-1:0] sc;
  logic [DW-1:0] dc;
  logic sample, dc_done, rep, nadd;
  assign sample = sc == SW'(SCAN_DIV - 1);
  assign dc_done = dc == DW'(DEBOUNCE_CNT - 1);
  assign kp.col_n = ~(4'b0001 << ci);
  always_comb begin
    row_idx = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    code = {row_idx, ci};
    acode = st == DEBOUNCE ? code : kp.key_code;
    nadd = acode == 4'hA ? 1'b1 : acode == 4'hC ? 1'b0 : kp.add;
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY);
  logic [RW-1:0] rc;
  assign rep = st == PRESSED && rows != 4'hF && rc == RW'(REPEAT_DLY - 1);
  // any exit from PRESSED, including the RELEASE bounce path, restarts the hold delay
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rc <= '0;
    else rc <= (st != PRESSED || rows == 4'hF || rep) ? '0 : rc + RW'(1);
`else
  assign rep = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 4'hF;
      rows <= 4'hF;
      pat <= 4'hF;
      st <= SCAN;
      ci <= 2'd0;
      sc <= '0;
      dc <= '0;
      kp.key_code <= 4'h0;
      kp.key_strobe <= 1'b0;
      kp.key_held <= 1'b0;
      kp.add <= 1'b0;
    end else begin
      s1 <= kp.row_n;
      rows <= s1;
      kp.key_strobe <= 1'b0;
      case (st)
        SCAN:
          if (sample) begin
            sc <= '0;
            if (rows != 4'hF) begin
              pat <= rows;
              dc <= '0;
              st <= DEBOUNCE;
            end else ci <= ci + 2'd1;
          end else sc <= sc + SW'(1);
        DEBOUNCE:
          if (rows != pat) begin
            st <= SCAN;
            ci <= ci + 2'd1;
            sc <= '0;
          end else if (dc_done) begin
            st <= PRESSED;
            kp.key_code <= code;
            kp.key_strobe <= 1'b1;
            kp.key_held <= 1'b1;
            kp.add <= nadd;
          end else dc <= dc + DW'(1);
        PRESSED:
          if (rows == 4'hF) begin
            st <= RELEASE;
            dc <= '0;
          end else if (rep) begin
            kp.key_strobe <= 1'b1;
            kp.add <= nadd;
          end
        default:
          if (rows != 4'hF) st <= PRESSED;
          else if (dc_done) begin
            st <= SCAN;
            kp.key_held <= 1'b0;
            ci <= ci + 2'd1;
            sc <= '0;
          end else dc <= dc + DW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad_scan against a physical keypad model and a key/add reference model
module tb_keypad_scan;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  keypad_scan_if kp();
  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_DLY(32)) dut (.clk(clk), .rst_n(rst_n), .kp(kp));
  logic [15:0] mask = '0;
  always_comb begin
    for (int r = 0; r < 4; r++) kp.row_n[r] = ~|(mask[r*4 +: 4] & ~kp.col_n);
  end
  int total = 0, bad = 0, cyc = 0, scnt = 0;
  logic [3:0] lcode = '0;
  logic ladd = 1'b0;
  int sq[$];
  int cq[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (kp.key_strobe) begin
      scnt <= scnt + 1;
      lcode <= kp.key_code;
      ladd <= kp.add;
      sq.push_back(cyc);
      cq.push_back(int'(kp.key_code));
    end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic press(input logic [15:0] m, input int hold, input int expc, input int expa);
    int n0 = scnt;
    int w = 0;
    mask = m;
    while (scnt == n0 && w < 40) begin
      tick();
      w++;
    end
    chk("strobe_seen", int'(scnt != n0), 1);
    chk("latency_bound", int'(w <= 28), 1);
    chk("key_code", int'(lcode), expc);
    chk("add_at_strobe", int'(ladd), expa);
    repeat (hold) tick();
    mask = '0;
    w = 0;
    while (kp.key_held && w < 30) begin
      tick();
      w++;
    end
    chk("held_fall_window", int'(w >= 8 && w < 30), 1);
    chk("one_strobe", scnt - n0, 1);
    repeat (6) tick();
  endtask
  typedef struct {
    logic [15:0] m;
    int hold;
    int code;
    int add;
  } vec_t;
  vec_t tbl[7];
  initial begin
    int n0, w, ts, run, k, madd, idx, nexp;
    tbl[0] = '{16'h0040, AR ? 20 : 80, 6, 0};
    tbl[1] = '{16'h0400, 20, 10, 1};
    tbl[2] = '{16'h0020, 20, 5, 1};
    tbl[3] = '{16'h1000, 20, 12, 0};
    tbl[4] = '{16'h1010, 20, 4, 0};
    tbl[5] = '{16'h0008, 20, 3, 0};
    tbl[6] = '{16'h8000, 20, 15, 0};
    repeat (3) tick();
    chk("rst_col_n", int'(kp.col_n), 14);
    chk("rst_key_code", int'(kp.key_code), 0);
    chk("rst_strobe", int'(kp.key_strobe), 0);
    chk("rst_held", int'(kp.key_held), 0);
    chk("rst_add", int'(kp.add), 0);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("col_rotate", int'(kp.col_n), int'(~(4'b0001 << ((n / 4) % 4))) & 15);
    end
    chk("idle_no_strobe", scnt, 0);
    for (int i = 0; i < 7; i++) press(tbl[i].m, tbl[i].hold, tbl[i].code, tbl[i].add);
    n0 = scnt;
    mask = 16'h0001;
    repeat (3) tick();
    mask = '0;
    repeat (2) tick();
    mask = 16'h0001;
    ts = cyc;
    w = 0;
    while (scnt == n0 && w < 40) begin
      tick();
      w++;
    end
    chk("bounce_strobe_seen", int'(scnt != n0), 1);
    chk("bounce_code", int'(lcode), 0);
    chk("bounce_stable_wait", int'(sq[$] - ts >= 10), 1);
    repeat (20) tick();
    mask = '0;
    repeat (30) tick();
    chk("bounce_one_strobe", scnt - n0, 1);
    madd = 0;
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 15);
      madd = k == 10 ? 1 : k == 12 ? 0 : madd;
      press(16'(1) << k, $urandom_range(5, 25), k, madd);
    end
    n0 = scnt;
    idx = sq.size();
    mask = 16'h0200;
    w = 0;
    while (scnt == n0 && w < 40) begin
      tick();
      w++;
    end
    repeat (100) tick();
    mask = '0;
    repeat (30) tick();
    nexp = AR ? 4 : 1;
    chk("hold9_strobes", scnt - n0, nexp);
    for (int i = 0; i < nexp && idx + i < sq.size(); i++) begin
      chk("hold9_offset", sq[idx+i] - sq[idx], 32 * i);
      chk("hold9_code", cq[idx+i], 9);
    end
    n0 = scnt;
    mask = 16'h1010;
    run = 0;
    w = 0;
    while (run < 5 && w < 60) begin
      tick();
      run = kp.col_n == 4'b1110 ? run + 1 : 0;
      w++;
    end
    chk("debounce_freeze", run, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_col_n", int'(kp.col_n), 14);
    chk("midrst_strobe", int'(kp.key_strobe), 0);
    repeat (5) tick();
    mask = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("midrst_no_strobe", scnt - n0, 0);
    chk("midrst_key_code", int'(kp.key_code), 0);
    chk("midrst_held", int'(kp.key_held), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Hex-keypad front end for the 4-digit adder datapath. It drives the columns of a 4×4 matrix keypad and samples its rows, then debounces each press. Each accepted press becomes a single-cycle `key_strobe` with a 4-bit `key_code`. It also maintains the `add` operand-select level consumed by the downstream digit-count/adder stage.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clk cycles each column stays driven; minimum 4.
- `DEBOUNCE_CNT`, default 20000: consecutive stable cycles needed to accept a press or a release; minimum 2.
- `REPEAT_DLY`, default 5000000: hold cycles between auto-repeat strobes. Used only with `KEYPAD_AUTOREPEAT_EN`.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `row_n`, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
- `col_n`, output, 4: keypad column drive, active-low, one-cold.
- `key_code`, output, 4: code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_strobe`, output, 1: one-cycle pulse when a new `key_code` is valid.
- `key_held`, output, 1: high while an accepted key remains pressed.
- `add`, output, 1: operand select for the downstream stage.

## Operation
- `row_n` passes through a 2-flop synchronizer; its reset value is 4'hF.
- Keypad layout is row-major hex: row0 = 0 1 2 3, row1 = 4 5 6 7, row2 = 8 9 A B, row3 = C D E F.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - `col_n` rotates 1110 → 1101 → 1011 → 0111 → 1110 …, advancing every `SCAN_DIV` cycles.
  - The synchronized rows are sampled on the last cycle of each column period.
  - If any row is low, latch the row pattern and the column index, freeze the column, and go to DEBOUNCE.
- DEBOUNCE:
  - The counter increments while the synchronized rows equal the latched pattern.
  - Any mismatch returns the FSM to SCAN; scanning resumes at the next column with a fresh period.
  - When the count reaches `DEBOUNCE_CNT`, go to PRESSED.
- Entry into PRESSED:
  - `key_code` loads the encoded key. If several rows are low, the lowest row index wins.
  - `key_strobe` pulses once and `key_held` rises.
  - Code 4'hA sets `add` to 1; code 4'hC clears `add` to 0.
  - Other codes leave `add` unchanged. Codes A and C still strobe.
- PRESSED: the column stays frozen. When all rows read high, go to RELEASE.
- RELEASE:
  - Requires all rows high for `DEBOUNCE_CNT` consecutive cycles; any low row returns the FSM to PRESSED without a new strobe.
  - On completion, `key_held` falls and the FSM goes to SCAN, continuing at the next column.
- `key_code` holds its value until the next strobe.

## Timing
- Reset values: `col_n` = 4'b1110, `key_code` = 0, `key_strobe` = 0, `key_held` = 0, `add` = 0. FSM = SCAN, all counters = 0.
- Reset asserted mid-operation returns everything to the reset values immediately. No strobe is emitted on reset release.
- Column settle time is `SCAN_DIV` − 3 cycles, after accounting for the synchronizer.
- Press latency: from the row-low edge to `key_strobe` takes at most 2 + `SCAN_DIV`×4 + `DEBOUNCE_CNT` + 1 cycles.
- Minimum latency, with the key already in the active column at sampling, is 2 + `DEBOUNCE_CNT` + 1 cycles.
- `key_strobe` and `key_code` change in the same cycle, so the consumer may register `key_code` on `key_strobe`.
- `add` updates in the strobe cycle and is a registered output.
- Counter widths use `$clog2` of their parameter.
- The scan counter wraps at `SCAN_DIV`−1; the column index wraps from 3 to 0.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter runs.
  - After every `REPEAT_DLY` held cycles, `key_strobe` pulses again with the same `key_code`, and the `add` rule is reapplied.
  - The counter clears whenever the FSM leaves PRESSED, including via RELEASE back into PRESSED.
- Not defined: exactly one strobe per press; the repeat logic is absent.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_CNT`=8, `REPEAT_DLY`=32.
- Reset, then idle with all rows high:
  - All outputs show their reset values.
  - `col_n` cycles through 1110, 1101, 1011, 0111, changing every 4 clks.
- Hold row1 low while col2 is driven, clean press for 100 clks:
  - Exactly one `key_strobe`, with `key_code` = 4'h6.
  - `key_held` stays high until 8 clks after release.
- Bounce row0/col0 low 3 clks, high 2, low 3, then stable low:
  - Strobe only after 8 stable cycles, with `key_code` = 0.
  - Exactly one strobe in total.
- Press A then C:
  - `add` goes 0→1 at the A strobe and 1→0 at the C strobe.
  - Press key 5 between them: `add` stays 1.
- Rows 1 and 3 low together in col0:
  - `key_code` = 4'h4.
  - Assert `rst_n` low mid-DEBOUNCE: no strobe, `col_n` = 1110.
- With `KEYPAD_AUTOREPEAT_EN`, hold key 9 for 100 clks after acceptance:
  - Strobes occur at acceptance, then at +32, +64 and +96 clks.
  - All four strobes carry `key_code` = 4'h9.
